// File: rtl/add_pkg.sv
// Shared types and helpers for the carry-lookahead adder slice.
// Group generate/propagate helper plus the registered flag bundle.
package add_pkg;

   localparam int unsigned GROUP_W = 4;

   typedef struct packed {
      logic g;
      logic p;
   } grp_gp_t;

   typedef struct packed {
      logic cout;
      logic ovf;
      logic zero;
   } flags_t;

   localparam flags_t FLAGS_RST = '{cout: 1'b0, ovf: 1'b0, zero: 1'b1};

   // Lookahead-form group generate/propagate from per-bit g/p.
   function automatic grp_gp_t group_gp(input logic [3:0] g, input logic [3:0] p);
      grp_gp_t r;
      r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      r.p = &p;
      return r;
   endfunction

endpackage

// File: rtl/cla4_group.sv
// 4-bit carry-lookahead group: sum, carry-out, group G/P and the carry
// into the top bit (needed by the parent for signed overflow).
module cla4_group
   import add_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout,
   output logic       G,
   output logic       P,
   output logic       c3
);

   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] c;
   grp_gp_t    gp;

   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
      gp   = group_gp(g, p);
      G    = gp.g;
      P    = gp.p;
      cout = gp.g | (gp.p & cin);
      s    = p ^ c;
      c3   = c[3];
   end

endmodule

// File: rtl/add8_cla.sv
// Ripple-of-groups carry-lookahead adder slice with a combinational sum
// path and a one-cycle registered copy carrying valid, overflow and zero flags.
module add8_cla
   import add_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned GROUP = GROUP_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             in_valid,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic [WIDTH-1:0] s_q,
   output logic             cout_q,
   output logic             ovf_q,
   output logic             zero_q,
   output logic             out_valid
);

   localparam int unsigned NGRP = WIDTH / GROUP;

   logic [NGRP:0]   gc;
   logic [NGRP-1:0] grp_cout;
   logic [NGRP-1:0] grp_g;
   logic [NGRP-1:0] grp_p;
   logic [NGRP-1:0] grp_c3;
   logic            ovf;

   assign gc[0] = cin;

   for (genvar k = 0; k < NGRP; k++) begin : g_grp
      cla4_group u_grp (
         .a    (a[k*4 +: 4]),
         .b    (b[k*4 +: 4]),
         .cin  (gc[k]),
         .s    (s[k*4 +: 4]),
         .cout (grp_cout[k]),
         .G    (grp_g[k]),
         .P    (grp_p[k]),
         .c3   (grp_c3[k])
      );
      if (k < NGRP - 1) begin : g_rip
         assign gc[k+1] = grp_cout[k];
      end
   end

   // Slice carry-out via block-level lookahead over all group G/P terms.
   always_comb begin
      logic blk_g;
      logic blk_p;
      blk_g = 1'b0;
      blk_p = 1'b1;
      for (int k = 0; k < int'(NGRP); k++) begin
         blk_g = grp_g[k] | (grp_p[k] & blk_g);
         blk_p = blk_p & grp_p[k];
      end
      gc[NGRP] = blk_g | (blk_p & cin);
   end

   assign cout = gc[NGRP];
   assign ovf  = grp_cout[NGRP-1] ^ grp_c3[NGRP-1];

   logic [WIDTH-1:0] sum_d, sum_q;
   flags_t           flags_d, flags_q;
   logic             valid_d, valid_q;

   always_comb begin
      sum_d   = sum_q;
      flags_d = flags_q;
      valid_d = 1'b0;
      if (in_valid) begin
         sum_d   = s;
         flags_d = '{cout: cout, ovf: ovf, zero: (s == '0)};
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q   <= '0;
         flags_q <= FLAGS_RST;
         valid_q <= 1'b0;
      end else begin
         sum_q   <= sum_d;
         flags_q <= flags_d;
         valid_q <= valid_d;
      end
   end

   assign s_q       = sum_q;
   assign cout_q    = flags_q.cout;
   assign ovf_q     = flags_q.ovf;
   assign zero_q    = flags_q.zero;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_add8_cla.sv
// Directed and random checks for add8_cla, including a two-slice cascade.
module tb_add8_cla;

   logic       clk;
   logic       rst;
   logic [7:0] a_lo, b_lo, a_hi, b_hi;
   logic       cin_lo, vin_lo, vin_hi;
   logic [7:0] s_lo, sq_lo, s_hi, sq_hi;
   logic       cout_lo, coutq_lo, ovfq_lo, zeroq_lo, vout_lo;
   logic       cout_hi, coutq_hi, ovfq_hi, zeroq_hi, vout_hi;

   int checks   = 0;
   int failures = 0;

   add8_cla #(.WIDTH(8), .GROUP(4)) u_lo (
      .clk       (clk),
      .rst       (rst),
      .a         (a_lo),
      .b         (b_lo),
      .cin       (cin_lo),
      .in_valid  (vin_lo),
      .s         (s_lo),
      .cout      (cout_lo),
      .s_q       (sq_lo),
      .cout_q    (coutq_lo),
      .ovf_q     (ovfq_lo),
      .zero_q    (zeroq_lo),
      .out_valid (vout_lo)
   );

   add8_cla #(.WIDTH(8), .GROUP(4)) u_hi (
      .clk       (clk),
      .rst       (rst),
      .a         (a_hi),
      .b         (b_hi),
      .cin       (cout_lo),
      .in_valid  (vin_hi),
      .s         (s_hi),
      .cout      (cout_hi),
      .s_q       (sq_hi),
      .cout_q    (coutq_hi),
      .ovf_q     (ovfq_hi),
      .zero_q    (zeroq_hi),
      .out_valid (vout_hi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic v);
      a_lo   = a;
      b_lo   = b;
      cin_lo = c;
      vin_lo = v;
      #1;
   endtask

   task automatic check_regs(input string tag, input logic [7:0] sq, input logic cq,
                             input logic oq, input logic zq, input logic vq);
      check({tag, ".s_q"},       {8'h0, sq_lo},   {8'h0, sq});
      check({tag, ".cout_q"},    {15'h0, coutq_lo}, {15'h0, cq});
      check({tag, ".ovf_q"},     {15'h0, ovfq_lo},  {15'h0, oq});
      check({tag, ".zero_q"},    {15'h0, zeroq_lo}, {15'h0, zq});
      check({tag, ".out_valid"}, {15'h0, vout_lo},  {15'h0, vq});
   endtask

   initial begin
      rst = 1'b0;
      a_hi = 8'h00; b_hi = 8'h00; vin_hi = 1'b0;
      drive(8'h00, 8'h00, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      check_regs("reset", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // 16-bit subtract 15010 - 1100 as two cascaded slices
      a_hi = 8'h3A; b_hi = 8'hFB;
      drive(8'hA2, 8'hB3, 1'b1, 1'b0);
      check("casc.lo.s",    {8'h0, s_lo},     16'h0056);
      check("casc.lo.cout", {15'h0, cout_lo}, 16'h0001);
      check("casc.hi.s",    {8'h0, s_hi},     16'h0036);
      check("casc.hi.cout", {15'h0, cout_hi}, 16'h0001);
      check("casc.sum16",   {s_hi, s_lo},     16'd13910);

      // Wrap-around through every group
      @(posedge clk); #1;
      drive(8'hFF, 8'h00, 1'b1, 1'b1);
      check("wrap.s",    {8'h0, s_lo},     16'h0000);
      check("wrap.cout", {15'h0, cout_lo}, 16'h0001);
      @(posedge clk); #1;
      check_regs("wrap", 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);

      // Positive overflow
      drive(8'h7F, 8'h01, 1'b0, 1'b1);
      check("ovfp.s",    {8'h0, s_lo},     16'h0080);
      check("ovfp.cout", {15'h0, cout_lo}, 16'h0000);
      @(posedge clk); #1;
      check_regs("ovfp", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);

      // Negative overflow
      drive(8'h80, 8'h80, 1'b0, 1'b1);
      check("ovfn.s",    {8'h0, s_lo},     16'h0000);
      check("ovfn.cout", {15'h0, cout_lo}, 16'h0001);
      @(posedge clk); #1;
      check_regs("ovfn", 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);

      // Capture then hold with in_valid low
      drive(8'h12, 8'h34, 1'b0, 1'b1);
      @(posedge clk); #1;
      check_regs("cap", 8'h46, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(8'h01, 8'h02, 1'b0, 1'b0);
      check("hold.s", {8'h0, s_lo}, 16'h0003);
      @(posedge clk); #1;
      check_regs("hold", 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);
      check("hold.s2", {8'h0, s_lo}, 16'h0003);

      // Asynchronous reset between edges, with a capture pending
      vin_lo = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check_regs("arst", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      check("arst.s", {8'h0, s_lo}, 16'h0003);
      @(posedge clk); #1;
      check_regs("arst.edge", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check_regs("post", 8'h03, 1'b0, 1'b0, 1'b0, 1'b1);

      // Random sweep: combinational now, registered one edge later
      for (int i = 0; i < 1000; i++) begin
         logic [7:0] ra, rb;
         logic       rc;
         logic [8:0] full;
         logic       rov;
         ra   = 8'($urandom);
         rb   = 8'($urandom);
         rc   = 1'($urandom);
         full = {1'b0, ra} + {1'b0, rb} + {8'h0, rc};
         rov  = (ra[7] == rb[7]) && (full[7] != ra[7]);
         drive(ra, rb, rc, 1'b1);
         check("rnd.sum", {7'h0, cout_lo, s_lo}, {7'h0, full});
         @(posedge clk); #1;
         check("rnd.reg", {4'h0, vout_lo, zeroq_lo, ovfq_lo, coutq_lo, sq_lo},
               {4'h0, 1'b1, (full[7:0] == 8'h00), rov, full[8], full[7:0]});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
